// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetron rotation controller.
package tetris_pkg;

    localparam int unsigned OFF_W       = 5;
    localparam int unsigned ROT_W       = 3;
    localparam int unsigned POS_W       = 5;
    localparam int unsigned SUM_W       = 7;
    localparam int unsigned NUM_BLK     = 4;
    localparam int unsigned OFFS_W      = OFF_W * NUM_BLK;
    localparam int unsigned KICK_W      = 2;
    localparam int unsigned BLK_W       = 2;
    localparam int unsigned DEF_BOARD_W = 10;
    localparam int unsigned DEF_BOARD_H = 20;
    localparam int unsigned DEF_NUM_ROT = 4;

    typedef enum logic [2:0] {
        IDLE,
        SHAPE,
        READ,
        EVAL,
        FIN
    } rot_state_t;

    // Pick block k's 5-bit offset out of the packed shaper bus.
    function automatic logic [OFF_W-1:0] blk_off(input logic [OFFS_W-1:0] offs,
                                                 input logic [BLK_W-1:0]  k);
        logic [OFF_W-1:0] r;
        case (k)
            2'd0:    r = offs[4:0];
            2'd1:    r = offs[9:5];
            2'd2:    r = offs[14:10];
            default: r = offs[19:15];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tetron_cell_addr.sv
// Combinational cell address: axis + block offset + kick, with playfield bounds check.
module tetron_cell_addr
    import tetris_pkg::*;
#(
    parameter int unsigned BOARD_W = DEF_BOARD_W,
    parameter int unsigned BOARD_H = DEF_BOARD_H
) (
    input  logic [POS_W-1:0]  base_row,
    input  logic [POS_W-1:0]  base_col,
    input  logic [OFF_W-1:0]  voff,
    input  logic [OFF_W-1:0]  hoff,
    input  logic [KICK_W-1:0] kick,
    output logic [POS_W-1:0]  row,
    output logic [POS_W-1:0]  col,
    output logic              oob
);

    localparam logic signed [SUM_W-1:0] ROW_LIM = SUM_W'(BOARD_H);
    localparam logic signed [SUM_W-1:0] COL_LIM = SUM_W'(BOARD_W);

    logic signed [SUM_W-1:0] row_s;
    logic signed [SUM_W-1:0] col_s;

    always_comb begin
        row_s = $signed({2'b00, base_row}) + $signed({{2{voff[OFF_W-1]}}, voff});
        col_s = $signed({2'b00, base_col}) + $signed({{2{hoff[OFF_W-1]}}, hoff})
              + $signed({{5{kick[KICK_W-1]}}, kick});
        oob   = row_s[SUM_W-1] || (row_s >= ROW_LIM) ||
                col_s[SUM_W-1] || (col_s >= COL_LIM);
        row   = row_s[POS_W-1:0];
        col   = col_s[POS_W-1:0];
    end

endmodule

// File: rtl/tetron_rotate_ctrl.sv
// Rotation controller: asks the shaper for a candidate rotation, probes four board cells, commits or rejects.
// Optional wall kick (+1 then -1 column retries) enabled by defining TETRON_WALLKICK_EN.
module tetron_rotate_ctrl
    import tetris_pkg::*;
#(
    parameter int unsigned BOARD_W = DEF_BOARD_W,
    parameter int unsigned BOARD_H = DEF_BOARD_H,
    parameter int unsigned NUM_ROT = DEF_NUM_ROT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rot_req,
    input  logic              rot_dir,
    input  logic              new_piece,
    input  logic [POS_W-1:0]  piece_row,
    input  logic [POS_W-1:0]  piece_col,
    output logic              shp_active,
    output logic [ROT_W-1:0]  shp_rotation,
    input  logic [OFFS_W-1:0] shp_voff,
    input  logic [OFFS_W-1:0] shp_hoff,
    output logic              brd_rd_en,
    output logic [POS_W-1:0]  brd_rd_row,
    output logic [POS_W-1:0]  brd_rd_col,
    input  logic              brd_rd_data,
    output logic [ROT_W-1:0]  cur_rotation,
    output logic              busy,
    output logic              done,
    output logic              accepted,
    output logic [KICK_W-1:0] kick_dh
);

    localparam logic [ROT_W-1:0]  ROT_LAST = ROT_W'(NUM_ROT - 1);
    localparam logic [KICK_W-1:0] KICK_0   = 2'b00;
`ifdef TETRON_WALLKICK_EN
    localparam logic [KICK_W-1:0] KICK_P1  = 2'b01;
    localparam logic [KICK_W-1:0] KICK_M1  = 2'b11;
`endif

    rot_state_t        state, state_d;
    logic [ROT_W-1:0]  cand, cand_d, cur_d;
    logic [POS_W-1:0]  row_q, col_q, row_d, col_d;
    logic [BLK_W-1:0]  k, k_d;
    logic [KICK_W-1:0] kick, kick_d, kick_dh_d;
    logic              done_d, acc_d, pass, fail;
    logic              cell_oob;

    tetron_cell_addr #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H)
    ) u_cell_addr (
        .base_row (row_q),
        .base_col (col_q),
        .voff     (blk_off(shp_voff, k)),
        .hoff     (blk_off(shp_hoff, k)),
        .kick     (kick),
        .row      (brd_rd_row),
        .col      (brd_rd_col),
        .oob      (cell_oob)
    );

    // Next-state and commit logic.
    always_comb begin
        state_d   = state;
        cand_d    = cand;
        row_d     = row_q;
        col_d     = col_q;
        k_d       = k;
        kick_d    = kick;
        cur_d     = cur_rotation;
        kick_dh_d = kick_dh;
        done_d    = 1'b0;
        acc_d     = 1'b0;
        pass      = 1'b0;
        fail      = 1'b0;

        case (state)
            IDLE: begin
                if (rot_req) begin
                    row_d   = piece_row;
                    col_d   = piece_col;
                    kick_d  = KICK_0;
                    if (rot_dir)
                        cand_d = (cur_rotation == '0) ? ROT_LAST : cur_rotation - ROT_W'(1);
                    else
                        cand_d = (cur_rotation == ROT_LAST) ? '0 : cur_rotation + ROT_W'(1);
                    state_d = SHAPE;
                end
            end
            SHAPE: begin
                k_d     = '0;
                state_d = READ;
            end
            READ: begin
                if (cell_oob) fail = 1'b1;
                else          state_d = EVAL;
            end
            EVAL: begin
                if (brd_rd_data) begin
                    fail = 1'b1;
                end else if (k == BLK_W'(NUM_BLK - 1)) begin
                    pass = 1'b1;
                end else begin
                    k_d     = k + BLK_W'(1);
                    state_d = READ;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (pass) begin
            cur_d     = cand;
            kick_dh_d = kick;
            acc_d     = 1'b1;
            done_d    = 1'b1;
            state_d   = FIN;
        end

        if (fail) begin
`ifdef TETRON_WALLKICK_EN
            if (kick == KICK_0) begin
                kick_d  = KICK_P1;
                state_d = SHAPE;
            end else if (kick == KICK_P1) begin
                kick_d  = KICK_M1;
                state_d = SHAPE;
            end else begin
                done_d  = 1'b1;
                state_d = FIN;
            end
`else
            done_d  = 1'b1;
            state_d = FIN;
`endif
        end

        // A new piece discards any in-flight attempt.
        if (new_piece) begin
            state_d   = IDLE;
            cur_d     = '0;
            kick_dh_d = KICK_0;
            done_d    = 1'b0;
            acc_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cand         <= '0;
            row_q        <= '0;
            col_q        <= '0;
            k            <= '0;
            kick         <= KICK_0;
            cur_rotation <= '0;
            kick_dh      <= KICK_0;
            done         <= 1'b0;
            accepted     <= 1'b0;
        end else begin
            state        <= state_d;
            cand         <= cand_d;
            row_q        <= row_d;
            col_q        <= col_d;
            k            <= k_d;
            kick         <= kick_d;
            cur_rotation <= cur_d;
            kick_dh      <= kick_dh_d;
            done         <= done_d;
            accepted     <= acc_d;
        end
    end

    always_comb begin
        busy         = (state != IDLE);
        shp_active   = (state == SHAPE) || (state == READ) || (state == EVAL);
        shp_rotation = shp_active ? cand : cur_rotation;
        brd_rd_en    = (state == READ) && !cell_oob;
    end

endmodule

// File: tb/tb_tetron_rotate_ctrl.sv
// Directed bench for tetron_rotate_ctrl; expectations follow TETRON_WALLKICK_EN when defined.
module tb_tetron_rotate_ctrl;

`ifdef TETRON_WALLKICK_EN
    localparam bit KICK = 1'b1;
`else
    localparam bit KICK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, rot_req, rot_dir, new_piece;
    logic [4:0]  piece_row, piece_col;
    logic        shp_active;
    logic [2:0]  shp_rotation;
    logic [19:0] shp_voff, shp_hoff;
    logic        brd_rd_en;
    logic [4:0]  brd_rd_row, brd_rd_col;
    logic        brd_rd_data;
    logic [2:0]  cur_rotation;
    logic        busy, done, accepted;
    logic [1:0]  kick_dh;

    logic        occ_en;
    logic [4:0]  occ_row, occ_col;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tetron_rotate_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rot_req      (rot_req),
        .rot_dir      (rot_dir),
        .new_piece    (new_piece),
        .piece_row    (piece_row),
        .piece_col    (piece_col),
        .shp_active   (shp_active),
        .shp_rotation (shp_rotation),
        .shp_voff     (shp_voff),
        .shp_hoff     (shp_hoff),
        .brd_rd_en    (brd_rd_en),
        .brd_rd_row   (brd_rd_row),
        .brd_rd_col   (brd_rd_col),
        .brd_rd_data  (brd_rd_data),
        .cur_rotation (cur_rotation),
        .busy         (busy),
        .done         (done),
        .accepted     (accepted),
        .kick_dh      (kick_dh)
    );

    // Shaper: blocks at (0,0) (0,+1) (-1,0) (+1,0); board: one optional occupied cell.
    always @(posedge clk) begin
        shp_voff    <= {5'd1, 5'h1F, 5'd0, 5'd0};
        shp_hoff    <= {5'd0, 5'd0, 5'd1, 5'd0};
        brd_rd_data <= brd_rd_en && occ_en && (brd_rd_row == occ_row) && (brd_rd_col == occ_col);
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic dir, input logic [4:0] r, input logic [4:0] c);
        @(negedge clk);
        rot_req = 1'b1; rot_dir = dir; piece_row = r; piece_col = c;
        @(negedge clk);
        rot_req = 1'b0;
    endtask

    // Request, then follow to done; n counts cycles after the request edge.
    task automatic run_case(input string tag, input logic dir, input logic [4:0] r,
                            input logic [4:0] c, input int exp_cand, input int pulse_at,
                            input int exp_cyc, input int exp_reads, input int exp_acc,
                            input int exp_cur, input int exp_kick);
        int dcyc, nreads, acc;
        dcyc = -1; nreads = 0; acc = -1;
        start_req(dir, r, c);
        chk({tag, ".shp_active"}, int'(shp_active), 1);
        chk({tag, ".shp_rotation"}, int'(shp_rotation), exp_cand);
        for (int n = 1; n <= 40; n++) begin
            rot_req = (n == pulse_at);
            rot_dir = ~dir;
            if (brd_rd_en) nreads++;
            if (done) begin
                dcyc = n;
                acc  = int'(accepted);
                break;
            end
            @(negedge clk);
        end
        rot_req = 1'b0;
        chk({tag, ".done_cycle"}, dcyc, exp_cyc);
        chk({tag, ".reads"}, nreads, exp_reads);
        chk({tag, ".accepted"}, acc, exp_acc);
        chk({tag, ".cur_rotation"}, int'(cur_rotation), exp_cur);
        chk({tag, ".kick_dh"}, int'(kick_dh), exp_kick);
    endtask

    task automatic wait_read(input string tag);
        int seen;
        seen = 0;
        for (int n = 0; n < 12 && seen == 0; n++) begin
            if (brd_rd_en) seen = 1;
            else @(negedge clk);
        end
        chk({tag, ".read_seen"}, seen, 1);
    endtask

    task automatic watch_no_done(input string tag);
        int seen;
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk({tag, ".no_done"}, seen, 0);
    endtask

    initial begin
        rst = 1'b1; rot_req = 1'b0; rot_dir = 1'b0; new_piece = 1'b0;
        piece_row = '0; piece_col = '0;
        occ_en = 1'b0; occ_row = '0; occ_col = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.cur_rotation", int'(cur_rotation), 0);
        chk("rst.shp_active", int'(shp_active), 0);
        chk("rst.brd_rd_en", int'(brd_rd_en), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.busy", int'(busy), 0);
        chk("idle.shp_rotation", int'(shp_rotation), 0);

        run_case("cw_basic", 1'b0, 5'd10, 5'd5, 1, 0, 10, 4, 1, 1, 0);
        @(negedge clk);
        chk("cw_basic.done_pulse", int'(done), 0);

        @(negedge clk); new_piece = 1'b1;
        @(negedge clk); new_piece = 1'b0;
        chk("newpiece.cur_rotation", int'(cur_rotation), 0);

        run_case("ccw_wrap", 1'b1, 5'd10, 5'd5, 3, 0, 10, 4, 1, 3, 0);

        run_case("top_oob", 1'b0, 5'd0, 5'd5, 0, 0, KICK ? 19 : 7, KICK ? 6 : 2, 0, 3, 0);

        occ_en = 1'b1; occ_row = 5'd11; occ_col = 5'd5;
        run_case("occupied", 1'b0, 5'd10, 5'd5, 0, 0, KICK ? 19 : 10, KICK ? 8 : 4,
                 KICK ? 1 : 0, KICK ? 0 : 3, KICK ? 1 : 0);
        occ_en = 1'b0;

        run_case("right_oob", 1'b0, 5'd10, 5'd9, KICK ? 1 : 0, 0, KICK ? 16 : 5,
                 KICK ? 5 : 1, KICK ? 1 : 0, KICK ? 1 : 3, KICK ? 3 : 0);

        run_case("busy_req", 1'b0, 5'd10, 5'd5, KICK ? 2 : 0, 3, 10, 4, 1, KICK ? 2 : 0, 0);
        watch_no_done("busy_req");
        chk("busy_req.busy", int'(busy), 0);

        // Abort from READ with new_piece.
        start_req(1'b0, 5'd10, 5'd5);
        wait_read("abort");
        new_piece = 1'b1;
        @(negedge clk);
        new_piece = 1'b0;
        chk("abort.busy", int'(busy), 0);
        chk("abort.cur_rotation", int'(cur_rotation), 0);
        chk("abort.kick_dh", int'(kick_dh), 0);
        watch_no_done("abort");

        // Commit rotation 1, then reset asynchronously in EVAL of the next attempt.
        run_case("pre_rst", 1'b0, 5'd10, 5'd5, 1, 0, 10, 4, 1, 1, 0);
        start_req(1'b0, 5'd10, 5'd5);
        wait_read("rst_eval");
        @(negedge clk);
        chk("rst_eval.in_flight", int'(shp_active), 1);
        rst = 1'b1;
        #1;
        chk("rst_eval.busy", int'(busy), 0);
        chk("rst_eval.cur_rotation", int'(cur_rotation), 0);
        chk("rst_eval.shp_active", int'(shp_active), 0);
        chk("rst_eval.shp_rotation", int'(shp_rotation), 0);
        chk("rst_eval.brd_rd_en", int'(brd_rd_en), 0);
        chk("rst_eval.done", int'(done), 0);
        chk("rst_eval.accepted", int'(accepted), 0);
        @(negedge clk);
        rst = 1'b0;
        watch_no_done("rst_eval");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
